// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 adder/subtractor (binary32 or binary64) with valid/ready handshake,
// round-to-nearest-even and {invalid, overflow, underflow, inexact} flags.
//
// state    | meaning
// IDLE     | waiting for operands, in_ready=1
// UNPACK   | decode fields, resolve NaN/inf/zero cases
// ALIGN    | order by magnitude, right-shift smaller mantissa with G/R/S
// ADD      | add or subtract, handle carry-out renormalisation
// NORM     | left-normalise one bit per cycle
// ROUND    | RNE rounding, overflow detection
// OUT      | result held until out_ready
module fp_addsub_seq #(
    parameter int X         = 32,
    parameter int expo_bits = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [X-1:0] A,
    input  logic [X-1:0] B,
    input  logic         op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [X-1:0] out,
    output logic [3:0]   flags
);
    localparam int E = expo_bits;
    localparam int M = X - E - 1;
    localparam int W = M + 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_ALIGN  = 3'd2;
    localparam logic [2:0] S_ADD    = 3'd3;
    localparam logic [2:0] S_NORM   = 3'd4;
    localparam logic [2:0] S_ROUND  = 3'd5;
    localparam logic [2:0] S_OUT    = 3'd6;

    localparam logic [X-1:0] QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    localparam logic [E:0]   EXP_ONE = (E+1)'(1);
    localparam logic [E:0]   EXP_MAX = {1'b0, {E{1'b1}}};
    localparam logic [E-1:0] D_MAX   = E'(M + 3);

    logic [2:0]   state;
    logic [X-1:0] a_q, b_q;
    logic         sign_l, eff_sub;
    logic [E:0]   exp_n;
    logic [W-1:0] mant_l, mant_s, norm;
    logic [X-1:0] out_q;
    logic [3:0]   flags_q;

    logic         sa, sb;
    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic         a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;

    assign sa = a_q[X-1];
    assign sb = b_q[X-1];
    assign ea = a_q[X-2:M];
    assign eb = b_q[X-2:M];
    assign fa = a_q[M-1:0];
    assign fb = b_q[M-1:0];

    assign a_nan  = (&ea) && (|fa);
    assign b_nan  = (&eb) && (|fb);
    assign a_snan = a_nan && !fa[M-1];
    assign b_snan = b_nan && !fb[M-1];
    assign a_inf  = (&ea) && !(|fa);
    assign b_inf  = (&eb) && !(|fb);
    // exponent 0 covers both true zeros and flushed denormals
    assign a_zero = (ea == '0);
    assign b_zero = (eb == '0);

    logic         spec_hit;
    logic [X-1:0] spec_out;
    logic [3:0]   spec_flags;

    always_comb begin
        spec_hit   = 1'b1;
        spec_out   = '0;
        spec_flags = '0;
        if (a_nan || b_nan) begin
            spec_out   = QNAN;
            spec_flags = {a_snan | b_snan, 3'b000};
        end else if (a_inf && b_inf && (sa != sb)) begin
            spec_out   = QNAN;
            spec_flags = 4'b1000;
        end else if (a_inf) begin
            spec_out = a_q;
        end else if (b_inf) begin
            spec_out = b_q;
        end else if (a_zero && b_zero) begin
            spec_out = {sa & sb, {(X-1){1'b0}}};
        end else if (a_zero) begin
            spec_out = b_q;
        end else if (b_zero) begin
            spec_out = a_q;
        end else begin
            spec_hit = 1'b0;
        end
    end

    logic         a_ge, l_s;
    logic [E-1:0] l_e, s_e, d;
    logic [M-1:0] l_f, s_f;
    logic [W-1:0] ext_l, ext_s, sh, shifted;

    always_comb begin
        a_ge  = {ea, fa} >= {eb, fb};
        l_s   = a_ge ? sa : sb;
        l_e   = a_ge ? ea : eb;
        s_e   = a_ge ? eb : ea;
        l_f   = a_ge ? fa : fb;
        s_f   = a_ge ? fb : fa;
        d     = l_e - s_e;
        ext_l = {1'b1, l_f, 3'b000};
        ext_s = {1'b1, s_f, 3'b000};
        sh    = ext_s >> d;
        // ext_s always has its hidden bit, so a full shift-out leaves only sticky
        if (d >= D_MAX)
            shifted = {{(W-1){1'b0}}, 1'b1};
        else
            shifted = {sh[W-1:1], sh[0] | ((sh << d) != ext_s)};
    end

    logic [W:0] sum;
    assign sum = eff_sub ? ({1'b0, mant_l} - {1'b0, mant_s})
                         : ({1'b0, mant_l} + {1'b0, mant_s});

    logic         rnd_up;
    logic [M:0]   frac_sum;
    logic [E:0]   exp_r;

    always_comb begin
        rnd_up   = norm[2] && (norm[1] || norm[0] || norm[3]);
        frac_sum = {1'b0, norm[W-2:3]} + {{M{1'b0}}, rnd_up};
        exp_r    = exp_n + {{E{1'b0}}, frac_sum[M]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sign_l  <= 1'b0;
            eff_sub <= 1'b0;
            exp_n   <= '0;
            mant_l  <= '0;
            mant_s  <= '0;
            norm    <= '0;
            out_q   <= '0;
            flags_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q   <= A;
                        b_q   <= {B[X-1] ^ op, B[X-2:0]};
                        state <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    if (spec_hit) begin
                        out_q   <= spec_out;
                        flags_q <= spec_flags;
                        state   <= S_OUT;
                    end else begin
                        state <= S_ALIGN;
                    end
                end
                S_ALIGN: begin
                    sign_l  <= l_s;
                    eff_sub <= sa ^ sb;
                    exp_n   <= {1'b0, l_e};
                    mant_l  <= ext_l;
                    mant_s  <= shifted;
                    state   <= S_ADD;
                end
                S_ADD: begin
                    if (eff_sub && (sum == '0)) begin
                        out_q   <= '0;
                        flags_q <= '0;
                        state   <= S_OUT;
                    end else if (sum[W]) begin
                        norm  <= {sum[W:2], sum[1] | sum[0]};
                        exp_n <= exp_n + EXP_ONE;
                        state <= S_ROUND;
                    end else begin
                        norm  <= sum[W-1:0];
                        state <= sum[W-1] ? S_ROUND : S_NORM;
                    end
                end
                S_NORM: begin
                    if (norm[W-1]) begin
                        state <= S_ROUND;
                    end else if (exp_n <= EXP_ONE) begin
                        out_q   <= {sign_l, {(X-1){1'b0}}};
                        flags_q <= 4'b0011;
                        state   <= S_OUT;
                    end else begin
                        norm  <= {norm[W-2:0], 1'b0};
                        exp_n <= exp_n - EXP_ONE;
                        if (norm[W-2])
                            state <= S_ROUND;
                    end
                end
                S_ROUND: begin
                    if (exp_r >= EXP_MAX) begin
                        out_q   <= {sign_l, {E{1'b1}}, {M{1'b0}}};
                        flags_q <= 4'b0101;
                    end else begin
                        out_q   <= {sign_l, exp_r[E-1:0], frac_sum[M-1:0]};
                        flags_q <= {3'b000, norm[2] | norm[1] | norm[0]};
                    end
                    state <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_OUT);
    assign out       = out_q;
    assign flags     = flags_q;

endmodule
